// File: rtl/reg_file_pkg.sv
// Shared constants, types and select helpers for the multi-ported register file.
// Imported by the register file top and its scoreboard.
package reg_file_pkg;

    localparam int XLEN          = 32;
    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int MAX_PORTS     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       reg_data_t;

    // Highest set bit of match as a one-hot vector; later ports take priority.
    function automatic logic [MAX_PORTS-1:0] onehot_last_match(
        input logic [MAX_PORTS-1:0] match
    );
        logic [MAX_PORTS-1:0] sel;
        sel = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (match[i]) sel = MAX_PORTS'(1) << i;
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy scoreboard: set on issue allocation, cleared on writeback.
// Exposes next-state busy so read ports can see same-cycle updates.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                alloc_en_i,
    input  logic [ADDR_W-1:0]   alloc_addr_i,
    input  logic [NUM_REGS-1:0] clr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [NUM_REGS-1:0] busy_nxt_o
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_alloc;

    // Out-of-range addresses match no register, so they drop out naturally.
    always_comb begin
        w_alloc = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_alloc[r] = alloc_en_i
                      && (alloc_addr_i == ADDR_W'(r))
                      && !(ZERO_REG != 0 && r == 0);
        end
    end

    assign busy_nxt_o = w_alloc | (r_busy & ~clr_i);
    assign busy_o     = r_busy;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= busy_nxt_o;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with write-to-read forwarding and busy scoreboard.
// Sits between decode/issue (reads, allocation) and writeback (writes).
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = NUM_ARCH_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     alloc_en_i,
    input  logic [ADDR_W-1:0]        alloc_addr_i,
    output logic [NUM_REGS-1:0]      busy_o,
    output logic                     wr_conflict_o
);

    if (NUM_RD < 1) begin : g_chk_rd
        $error("reg_file_mp: NUM_RD must be >= 1");
    end
    if (NUM_WR < 1 || NUM_WR > MAX_PORTS) begin : g_chk_wr
        $error("reg_file_mp: NUM_WR must be in 1..MAX_PORTS");
    end
    if (NUM_REGS < 2) begin : g_chk_regs
        $error("reg_file_mp: NUM_REGS must be >= 2");
    end
    if (DATA_W < 1) begin : g_chk_dw
        $error("reg_file_mp: DATA_W must be >= 1");
    end

    localparam logic [ADDR_W:0] L_NREGS = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   r_regs    [NUM_REGS];
    logic [DATA_W-1:0]   w_wr_data [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_busy_nxt;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < L_NREGS;
    endfunction

    // A register that can actually hold data: in range and not hardwired zero.
    function automatic logic f_live(input logic [ADDR_W-1:0] a);
        return f_in_range(a) && !(ZERO_REG != 0 && a == '0);
    endfunction

    always_comb begin
        logic [NUM_WR-1:0] w_m;
        logic [NUM_WR-1:0] w_s;
        w_m      = '0;
        w_s      = '0;
        w_wr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_m = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                w_m[k] = wr_en_i[k]
                      && wr_addr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r)
                      && f_live(ADDR_W'(r));
            end
            w_s          = NUM_WR'(onehot_last_match(MAX_PORTS'(w_m)));
            w_wr_hit[r]  = |w_m;
            w_wr_data[r] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_s[k]) w_wr_data[r] = wr_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_aj;
        wr_conflict_o = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_aj = wr_addr_i[j*ADDR_W +: ADDR_W];
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_en_i[j] && wr_en_i[k]
                    && w_aj == wr_addr_i[k*ADDR_W +: ADDR_W]
                    && w_aj != '0 && f_in_range(w_aj)) begin
                    wr_conflict_o = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_a;
        logic [DATA_W-1:0] w_d;
        logic [NUM_WR-1:0] w_m;
        logic [NUM_WR-1:0] w_s;
        rd_data_o = '0;
        rd_busy_o = '0;
        w_a       = '0;
        w_d       = '0;
        w_m       = '0;
        w_s       = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_a = rd_addr_i[i*ADDR_W +: ADDR_W];
            w_d = '0;
            w_m = '0;
            if (f_live(w_a)) begin
                w_d = r_regs[w_a];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        w_m[k] = wr_en_i[k]
                              && wr_addr_i[k*ADDR_W +: ADDR_W] == w_a;
                    end
                    w_s = NUM_WR'(onehot_last_match(MAX_PORTS'(w_m)));
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (w_s[k]) w_d = wr_data_i[k*DATA_W +: DATA_W];
                    end
                end
                rd_busy_o[i] = (BYPASS != 0) ? w_busy_nxt[w_a] : busy_o[w_a];
            end
            rd_data_o[i*DATA_W +: DATA_W] = w_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_wr_hit[r]) r_regs[r] <= w_wr_data[r];
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .alloc_en_i   (alloc_en_i),
        .alloc_addr_i (alloc_addr_i),
        .clr_i        (w_wr_hit),
        .busy_o       (busy_o),
        .busy_nxt_o   (w_busy_nxt)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default, no-bypass and wide/odd-size configurations
// driven with directed and random traffic against an array-based model.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus, index 0 = 32-reg configs, index 1 = 24-reg sweep config.
    logic        st_we [2][3];
    logic [4:0]  st_wa [2][3];
    logic [63:0] st_wd [2][3];
    logic [4:0]  st_ra [2][4];
    logic        st_ae [2];
    logic [4:0]  st_aa [2];

    logic [63:0] mreg  [2][32];
    logic        mbusy [2][32];

    logic [1:0]   a_we;
    logic [9:0]   a_wa;
    logic [63:0]  a_wd;
    logic [9:0]   a_ra;
    logic [63:0]  b_rd, n_rd;
    logic [1:0]   b_rb, n_rb;
    logic [31:0]  b_busy, n_busy;
    logic         b_cf, n_cf;

    logic [2:0]   s_we;
    logic [14:0]  s_wa;
    logic [191:0] s_wd;
    logic [19:0]  s_ra;
    logic [255:0] s_rd;
    logic [3:0]   s_rb;
    logic [23:0]  s_busy;
    logic         s_cf;

    for (genvar k = 0; k < 2; k++) begin : g_a
        assign a_we[k]         = st_we[0][k];
        assign a_wa[k*5 +: 5]  = st_wa[0][k];
        assign a_wd[k*32 +: 32] = st_wd[0][k][31:0];
        assign a_ra[k*5 +: 5]  = st_ra[0][k];
    end
    for (genvar k = 0; k < 3; k++) begin : g_sw
        assign s_we[k]          = st_we[1][k];
        assign s_wa[k*5 +: 5]   = st_wa[1][k];
        assign s_wd[k*64 +: 64] = st_wd[1][k];
    end
    for (genvar k = 0; k < 4; k++) begin : g_sr
        assign s_ra[k*5 +: 5] = st_ra[1][k];
    end

    reg_file_mp u_byp (
        .clk_i(clk), .reset_ni(rst_n),
        .wr_en_i(a_we), .wr_addr_i(a_wa), .wr_data_i(a_wd),
        .rd_addr_i(a_ra), .rd_data_o(b_rd), .rd_busy_o(b_rb),
        .alloc_en_i(st_ae[0]), .alloc_addr_i(st_aa[0]),
        .busy_o(b_busy), .wr_conflict_o(b_cf)
    );

    reg_file_mp #(.BYPASS(0)) u_nob (
        .clk_i(clk), .reset_ni(rst_n),
        .wr_en_i(a_we), .wr_addr_i(a_wa), .wr_data_i(a_wd),
        .rd_addr_i(a_ra), .rd_data_o(n_rd), .rd_busy_o(n_rb),
        .alloc_en_i(st_ae[0]), .alloc_addr_i(st_aa[0]),
        .busy_o(n_busy), .wr_conflict_o(n_cf)
    );

    reg_file_mp #(
        .DATA_W(64), .NUM_REGS(24), .NUM_RD(4), .NUM_WR(3)
    ) u_swp (
        .clk_i(clk), .reset_ni(rst_n),
        .wr_en_i(s_we), .wr_addr_i(s_wa), .wr_data_i(s_wd),
        .rd_addr_i(s_ra), .rd_data_o(s_rd), .rd_busy_o(s_rb),
        .alloc_en_i(st_ae[1]), .alloc_addr_i(st_aa[1]),
        .busy_o(s_busy), .wr_conflict_o(s_cf)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nregs(int c); return (c != 0) ? 24 : 32; endfunction
    function automatic int nwr(int c);   return (c != 0) ? 3 : 2;   endfunction
    function automatic int nrd(int c);   return (c != 0) ? 4 : 2;   endfunction

    function automatic logic live(int c, int a);
        return a != 0 && a < nregs(c);
    endfunction

    function automatic logic nxt_busy(int c, int r);
        if (!live(c, r)) return 1'b0;
        if (st_ae[c] && int'(st_aa[c]) == r) return 1'b1;
        for (int k = 0; k < nwr(c); k++)
            if (st_we[c][k] && int'(st_wa[c][k]) == r) return 1'b0;
        return mbusy[c][r];
    endfunction

    function automatic logic [63:0] exp_rd(int c, int i, bit byp);
        int a = int'(st_ra[c][i]);
        logic [63:0] v;
        if (!live(c, a)) return 64'h0;
        v = mreg[c][a];
        if (byp)
            for (int k = 0; k < nwr(c); k++)
                if (st_we[c][k] && int'(st_wa[c][k]) == a) v = st_wd[c][k];
        return v;
    endfunction

    function automatic logic exp_rb(int c, int i, bit byp);
        int a = int'(st_ra[c][i]);
        if (!live(c, a)) return 1'b0;
        return byp ? nxt_busy(c, a) : mbusy[c][a];
    endfunction

    function automatic logic exp_cf(int c);
        for (int j = 0; j < nwr(c); j++)
            for (int k = j + 1; k < nwr(c); k++)
                if (st_we[c][j] && st_we[c][k] && st_wa[c][j] == st_wa[c][k]
                    && live(c, int'(st_wa[c][j]))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] busy_vec(int c);
        logic [63:0] v = '0;
        for (int r = 0; r < nregs(c); r++) v[r] = mbusy[c][r];
        return v;
    endfunction

    task automatic commit(int c);
        logic nb [32];
        for (int r = 0; r < 32; r++) nb[r] = nxt_busy(c, r);
        for (int k = 0; k < nwr(c); k++)
            if (st_we[c][k] && live(c, int'(st_wa[c][k])))
                mreg[c][st_wa[c][k]] = st_wd[c][k];
        for (int r = 0; r < 32; r++) mbusy[c][r] = nb[r];
    endtask

    task automatic m_reset();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++) begin
                mreg[c][r]  = '0;
                mbusy[c][r] = 1'b0;
            end
    endtask

    task automatic idle();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) begin
                st_we[c][k] = 1'b0;
                st_wa[c][k] = '0;
                st_wd[c][k] = '0;
            end
            for (int i = 0; i < 4; i++) st_ra[c][i] = '0;
            st_ae[c] = 1'b0;
            st_aa[c] = '0;
        end
    endtask

    task automatic check_comb();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("byp rd%0d", i), {32'h0, b_rd[i*32 +: 32]}, exp_rd(0, i, 1));
            chk($sformatf("nob rd%0d", i), {32'h0, n_rd[i*32 +: 32]}, exp_rd(0, i, 0));
            chk($sformatf("byp rb%0d", i), 64'(b_rb[i]), 64'(exp_rb(0, i, 1)));
            chk($sformatf("nob rb%0d", i), 64'(n_rb[i]), 64'(exp_rb(0, i, 0)));
        end
        chk("byp conflict", 64'(b_cf), 64'(exp_cf(0)));
        chk("nob conflict", 64'(n_cf), 64'(exp_cf(0)));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("swp rd%0d", i), s_rd[i*64 +: 64], exp_rd(1, i, 1));
            chk($sformatf("swp rb%0d", i), 64'(s_rb[i]), 64'(exp_rb(1, i, 1)));
        end
        chk("swp conflict", 64'(s_cf), 64'(exp_cf(1)));
    endtask

    task automatic check_regs();
        chk("byp busy_o", {32'h0, b_busy}, busy_vec(0));
        chk("nob busy_o", {32'h0, n_busy}, busy_vec(0));
        chk("swp busy_o", {40'h0, s_busy}, busy_vec(1));
    endtask

    // Inputs are set at posedge+1; outputs compared at negedge, state after edge.
    task automatic do_cycle();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        if (rst_n) begin
            commit(0);
            commit(1);
        end
        #1;
        check_regs();
    endtask

    function automatic logic [4:0] rand_addr(int c, bit oor_ok);
        if (c == 0)
            return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                               : 5'($urandom_range(0, 7));
        if (oor_ok && $urandom_range(0, 7) == 0) return 5'($urandom_range(24, 31));
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7))
                                           : 5'($urandom_range(0, 23));
    endfunction

    task automatic rand_stim();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < nwr(c); k++) begin
                st_we[c][k] = 1'($urandom_range(0, 1));
                st_wa[c][k] = rand_addr(c, k == 0);
                st_wd[c][k] = (c != 0) ? {$urandom, $urandom} : {32'h0, $urandom};
            end
            for (int i = 0; i < nrd(c); i++) st_ra[c][i] = rand_addr(c, 1'b1);
            st_ae[c] = ($urandom_range(0, 2) == 0);
            st_aa[c] = rand_addr(c, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset busy_o", {32'h0, b_busy}, 64'h0);
        chk("reset swp busy_o", {40'h0, s_busy}, 64'h0);
        st_ra[0][0] = 5'd1;
        #2;
        chk("reset r1", {32'h0, b_rd[31:0]}, 64'h0);
        do_cycle();

        // Reset mid-traffic
        idle();
        st_we[0][0] = 1'b1; st_wa[0][0] = 5'd5; st_wd[0][0] = 64'hDEADBEEF;
        do_cycle();
        idle();
        st_ae[0] = 1'b1; st_aa[0] = 5'd5;
        do_cycle();
        idle();
        st_ra[0][0] = 5'd5;
        #2;
        chk("r5 before reset", {32'h0, b_rd[31:0]}, 64'hDEADBEEF);
        chk("busy5 before reset", 64'(b_busy[5]), 64'h1);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("r5 async reset", {32'h0, b_rd[31:0]}, 64'h0);
        chk("busy async reset", {32'h0, b_busy}, 64'h0);
        st_we[0][0] = 1'b1; st_wa[0][0] = 5'd6; st_wd[0][0] = 64'h1234;
        st_ae[0] = 1'b1; st_aa[0] = 5'd6;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        st_ra[0][0] = 5'd6;
        #1;
        chk("r6 discarded in reset", {32'h0, n_rd[31:0]}, 64'h0);
        chk("busy6 discarded in reset", 64'(b_busy[6]), 64'h0);
        @(posedge clk);
        #1;

        // Dual write conflict, highest port wins
        idle();
        st_we[0][0] = 1'b1; st_wa[0][0] = 5'd7; st_wd[0][0] = 64'h11111111;
        st_we[0][1] = 1'b1; st_wa[0][1] = 5'd7; st_wd[0][1] = 64'h22222222;
        #2;
        chk("dir conflict", 64'(b_cf), 64'h1);
        do_cycle();
        idle();
        st_ra[0][0] = 5'd7;
        #2;
        chk("dir r7 winner", {32'h0, n_rd[31:0]}, 64'h22222222);
        do_cycle();

        // Forwarding vs registered read
        idle();
        st_we[0][0] = 1'b1; st_wa[0][0] = 5'd3; st_wd[0][0] = 64'h0BADF00D;
        do_cycle();
        idle();
        st_we[0][1] = 1'b1; st_wa[0][1] = 5'd3; st_wd[0][1] = 64'hA5A5A5A5;
        st_ra[0][0] = 5'd3;
        #2;
        chk("dir bypass new", {32'h0, b_rd[31:0]}, 64'hA5A5A5A5);
        chk("dir nobypass old", {32'h0, n_rd[31:0]}, 64'h0BADF00D);
        do_cycle();
        idle();
        st_ra[0][0] = 5'd3;
        #2;
        chk("dir nobypass next", {32'h0, n_rd[31:0]}, 64'hA5A5A5A5);
        do_cycle();

        // Zero register
        idle();
        st_we[0][0] = 1'b1; st_wa[0][0] = 5'd0; st_wd[0][0] = 64'hFFFFFFFF;
        st_we[0][1] = 1'b1; st_wa[0][1] = 5'd0; st_wd[0][1] = 64'h12345678;
        st_ae[0] = 1'b1; st_aa[0] = 5'd0;
        #2;
        chk("dir r0 bypass", {32'h0, b_rd[31:0]}, 64'h0);
        chk("dir r0 conflict", 64'(b_cf), 64'h0);
        do_cycle();
        chk("dir busy0", 64'(b_busy[0]), 64'h0);
        idle();
        #2;
        chk("dir r0 stored", {32'h0, n_rd[31:0]}, 64'h0);
        do_cycle();

        // Scoreboard
        idle();
        st_ae[0] = 1'b1; st_aa[0] = 5'd9;
        do_cycle();
        chk("dir busy9 set", 64'(b_busy[9]), 64'h1);
        idle();
        st_we[0][0] = 1'b1; st_wa[0][0] = 5'd9; st_wd[0][0] = 64'h99;
        st_ae[0] = 1'b1; st_aa[0] = 5'd9;
        do_cycle();
        chk("dir busy9 alloc wins", 64'(n_busy[9]), 64'h1);
        idle();
        st_we[0][1] = 1'b1; st_wa[0][1] = 5'd9; st_wd[0][1] = 64'h55;
        st_ra[0][0] = 5'd9;
        st_ae[0] = 1'b1; st_aa[0] = 5'd10;
        st_ra[0][1] = 5'd10;
        #2;
        chk("dir rb9 bypass clear", 64'(b_rb[0]), 64'h0);
        chk("dir rb9 nobypass", 64'(n_rb[0]), 64'h1);
        chk("dir r9 stored", {32'h0, n_rd[31:0]}, 64'h99);
        chk("dir rb10 bypass alloc", 64'(b_rb[1]), 64'h1);
        chk("dir rb10 nobypass", 64'(n_rb[1]), 64'h0);
        do_cycle();
        chk("dir busy9 clear", 64'(b_busy[9]), 64'h0);

        // Sweep config boundaries
        idle();
        st_we[1][0] = 1'b1; st_wa[1][0] = 5'd30; st_wd[1][0] = 64'hCAFEF00D_01234567;
        st_we[1][2] = 1'b1; st_wa[1][2] = 5'd23; st_wd[1][2] = 64'h89ABCDEF_76543210;
        st_ra[1][0] = 5'd30;
        st_ae[1] = 1'b1; st_aa[1] = 5'd30;
        #2;
        chk("swp r30 read", s_rd[63:0], 64'h0);
        chk("swp rb30", 64'(s_rb[0]), 64'h0);
        do_cycle();
        idle();
        st_ra[1][0] = 5'd30;
        st_ra[1][3] = 5'd23;
        #2;
        chk("swp r30 dropped", s_rd[63:0], 64'h0);
        chk("swp r23 stored", s_rd[255:192], 64'h89ABCDEF_76543210);
        do_cycle();

        for (int n = 0; n < 400; n++) begin
            rand_stim();
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
